// File: rtl/vram_pkg.sv
// Shared types for the VRAM arbiter: bus owner encoding and the read-tag values
// stored per outstanding read.
package vram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        CPU  = 2'd2
    } owner_t;

    localparam logic TAG_SCAN = 1'b0;
    localparam logic TAG_CPU  = 1'b1;

endpackage

// File: rtl/vram_tag_fifo.sv
// Small FIFO of 1-bit owner tags, one entry per read accepted by the VRAM
// controller and not yet returned.
module vram_tag_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         din,
    output logic                         dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;

endmodule

// File: rtl/vram_arbiter.sv
// Two-requester arbiter (VGA scanout, CPU) in front of a pipelined Avalon-MM
// SDRAM controller; read data is steered back using a FIFO of owner tags.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W     = 24,
    parameter int STARVE_MAX = 16,
    parameter int PEND_DEPTH = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [ADDR_W-1:0]                 scan_address,
    input  logic                              scan_read,
    output logic                              scan_waitrequest,
    output logic [15:0]                       scan_readdata,
    output logic                              scan_readdatavalid,
    input  logic [ADDR_W-1:0]                 cpu_address,
    input  logic                              cpu_read,
    input  logic                              cpu_write,
    input  logic [15:0]                       cpu_writedata,
    input  logic [1:0]                        cpu_byteenable,
    output logic                              cpu_waitrequest,
    output logic [15:0]                       cpu_readdata,
    output logic                              cpu_readdatavalid,
    output logic [ADDR_W-1:0]                 vram_address,
    output logic                              vram_read,
    output logic                              vram_write,
    output logic [15:0]                       vram_writedata,
    output logic [1:0]                        vram_byteenable,
    input  logic                              vram_waitrequest,
    input  logic [15:0]                       vram_readdata,
    input  logic                              vram_readdatavalid,
    output logic                              err_orphan,
    output owner_t                            dbg_state,
    output logic [$clog2(STARVE_MAX+1)-1:0]   dbg_starve_cnt,
    output logic [$clog2(PEND_DEPTH+1)-1:0]   dbg_pend_count
);

    localparam int SC_W = $clog2(STARVE_MAX + 1);

    owner_t          state;
    owner_t          state_nxt;
    logic [SC_W-1:0] starve_cnt;
    logic            err_q;
    logic            grant_scan;
    logic            grant_cpu;
    logic            accept;
    logic            read_ok;
    logic            scan_elig;
    logic            cpu_elig;
    logic            cpu_pending;
    logic            cpu_starved;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_dout;
    logic            push;
    logic            pop;

    // Handshake: a command moves when (vram_read|vram_write) && !vram_waitrequest;
    // a requester sees waitrequest low only in that cycle, and read data is
    // qualified by readdatavalid alone, with no back-pressure.
    assign pop         = rst_n && vram_readdatavalid && !fifo_empty;
    assign read_ok     = !fifo_full || pop;
    assign cpu_pending = cpu_read || cpu_write;
    assign scan_elig   = scan_read && read_ok;
    assign cpu_elig    = cpu_write || (cpu_read && read_ok);
    assign cpu_starved = (starve_cnt == SC_W'(STARVE_MAX));

    always_comb begin
        grant_scan = 1'b0;
        grant_cpu  = 1'b0;
        state_nxt  = IDLE;
        if (rst_n) begin
            unique case (state)
                SCAN: grant_scan = scan_read;
                CPU:  grant_cpu  = cpu_pending;
                default: begin
                    if (scan_elig && !(cpu_elig && cpu_starved)) begin
                        grant_scan = 1'b1;
                    end else if (cpu_elig) begin
                        grant_cpu = 1'b1;
                    end
                end
            endcase
        end
        // Read+write from the CPU is issued as a write only.
        vram_read  = grant_scan || (grant_cpu && !cpu_write);
        vram_write = grant_cpu && cpu_write;
        accept     = (vram_read || vram_write) && !vram_waitrequest;
        if (grant_scan && !accept) begin
            state_nxt = SCAN;
        end else if (grant_cpu && !accept) begin
            state_nxt = CPU;
        end
    end

    assign vram_address    = grant_cpu ? cpu_address : scan_address;
    assign vram_writedata  = cpu_writedata;
    assign vram_byteenable = grant_cpu ? cpu_byteenable : 2'b11;

    assign scan_waitrequest = !(grant_scan && accept);
    assign cpu_waitrequest  = !(grant_cpu && accept);

    assign push = accept && vram_read;

    vram_tag_fifo #(
        .DEPTH (PEND_DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (grant_cpu ? TAG_CPU : TAG_SCAN),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (dbg_pend_count)
    );

    assign scan_readdata      = vram_readdata;
    assign cpu_readdata       = vram_readdata;
    assign scan_readdatavalid = pop && (fifo_dout == TAG_SCAN);
    assign cpu_readdatavalid  = pop && (fifo_dout == TAG_CPU);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            starve_cnt <= '0;
            err_q      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (!cpu_pending || (grant_cpu && accept)) begin
                starve_cnt <= '0;
            end else if (!cpu_starved) begin
                starve_cnt <= starve_cnt + SC_W'(1);
            end
            if (vram_readdatavalid && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_orphan     = err_q;
    assign dbg_state      = state;
    assign dbg_starve_cnt = starve_cnt;

endmodule
